// File: rtl/uart_tx_fifo_drain_pkg.sv
// Shared definitions for the UART FIFO-drain transmitter and its matching receiver:
// FSM state encoding and baud divider arithmetic.
package uart_tx_fifo_drain_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } tx_state_e;

  localparam int unsigned DEF_CLK_FREQ   = 100_000_000;
  localparam int unsigned DEF_BAUD       = 9600;
  localparam int unsigned DEF_OVERSAMPLE = 16;

  // Clocks per oversample tick, integer-truncated.
  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input int unsigned baud,
                                           input int unsigned oversample);
    return clk_freq / (baud * oversample);
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_drain_if.sv
// FIFO read port as seen by the drain engine: the drain is the master that pops,
// the FIFO is the slave that presents its head word and empty flag.
interface uart_tx_fifo_drain_if;
  logic       fifo_empty;
  logic [7:0] fifo_rdata;
  logic       fifo_rd;

  modport master (input fifo_empty, input fifo_rdata, output fifo_rd);
  modport slave  (output fifo_empty, output fifo_rdata, input fifo_rd);
endinterface

// File: rtl/uart_tx_fifo_drain_baud_tick_gen.sv
// Oversample tick generator: counts 0..DIV-1 and pulses tick for one clk at DIV-1.
// clear holds the count at zero so the following bit starts on a fresh period.
module baud_tick_gen
  import uart_tx_fifo_drain_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = DEF_CLK_FREQ,
  parameter int unsigned BAUD       = DEF_BAUD,
  parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned   DIV      = baud_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int unsigned   DW       = cnt_width(DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  logic [DW-1:0] div_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (clear || div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign tick = (div_cnt == DIV_LAST) && !clear;

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// Pops bytes from the FIFO while it is non-empty and sends each as an 8N1 frame, LSB first,
// with frames back to back separated only by the one-clk LOAD cycle.
module uart_tx_fifo_drain
  import uart_tx_fifo_drain_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = DEF_CLK_FREQ,
  parameter int unsigned BAUD       = DEF_BAUD,
  parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic                        clk,
  input  logic                        reset,
  uart_tx_fifo_drain_if.master        fifo,
  output logic                        tx,
  output logic                        tx_busy,
  output logic                        tx_done
);

  localparam int unsigned   TW        = cnt_width(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

  tx_state_e     state, state_nxt;
  logic [7:0]    shift_q;
  logic [2:0]    bit_cnt;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic          baud_clear;
  logic          bit_end;

  // Divider is held in IDLE/LOAD so the start bit begins a full period.
  assign baud_clear = (state == IDLE) || (state == LOAD);
  assign bit_end    = tick && (tick_cnt == TICK_LAST);

  baud_tick_gen #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_baud_tick_gen (
    .clk  (clk),
    .reset(reset),
    .clear(baud_clear),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: default assignments first keep combinational blocks free of inferred latches.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!fifo.fifo_empty) state_nxt = LOAD;
      LOAD:    state_nxt = START;
      START:   if (bit_end) state_nxt = DATA;
      DATA:    if (bit_end && bit_cnt == 3'd7) state_nxt = STOP;
      STOP:    if (bit_end) state_nxt = fifo.fifo_empty ? IDLE : LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx           = 1'b1;
    fifo.fifo_rd = 1'b0;
    tx_busy      = 1'b1;
    tx_done      = 1'b0;
    case (state)
      IDLE:    tx_busy = 1'b0;
      LOAD:    fifo.fifo_rd = 1'b1;
      START:   tx = 1'b0;
      DATA:    tx = shift_q[0];
      STOP:    tx_done = bit_end;
      default: tx_busy = 1'b0;
    endcase
  end

  // Tick counter wraps exactly at each bit boundary, so it is zero on every state entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (baud_clear) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
    end
  end

  // The byte is captured only in LOAD; the FIFO port is ignored for the rest of the frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        LOAD:  shift_q <= fifo.fifo_rdata;
        START: bit_cnt <= '0;
        DATA: begin
          if (bit_end) begin
            shift_q <= {1'b0, shift_q[7:1]};
            if (bit_cnt != 3'd7) bit_cnt <= bit_cnt + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Self-checking bench: a queue-based FIFO model feeds the drain engine and a line monitor
// compares every frame cycle by cycle against the ideal 8N1 waveform of the popped byte.
module tb_uart_tx_fifo_drain;

  localparam int unsigned CLK_FREQ   = 1_600_000;
  localparam int unsigned BAUD       = 10_000;
  localparam int unsigned OVERSAMPLE = 16;
  localparam int          BIT_CLKS   = 160;
  localparam int          FRAME_CLKS = 10 * BIT_CLKS;

  logic clk = 1'b0;
  logic reset;
  logic tx, tx_busy, tx_done;

  uart_tx_fifo_drain_if fif ();

  uart_tx_fifo_drain #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .fifo   (fif),
    .tx     (tx),
    .tx_busy(tx_busy),
    .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // FIFO model: head word is combinational; a pop takes effect after the LOAD edge.
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int         pops        = 0;
  int         bad_pops    = 0;
  bit         pop_pending = 1'b0;
  bit         ovr_en      = 1'b0;
  bit         ovr_empty   = 1'b1;
  logic [7:0] ovr_rdata   = 8'h00;

  initial begin : fifo_model
    fif.fifo_empty = 1'b1;
    fif.fifo_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (pop_pending && fifo_q.size() > 0) fifo_q.delete(0);
      pop_pending = 1'b0;
      if (fif.fifo_rd === 1'b1) begin
        pops++;
        if (fif.fifo_empty !== 1'b0) bad_pops++;
        else exp_q.push_back(fif.fifo_rdata);
        pop_pending = !ovr_en;
      end
      #1;
      if (ovr_en) begin
        fif.fifo_empty = ovr_empty;
        fif.fifo_rdata = ovr_rdata;
      end else begin
        fif.fifo_empty = (fifo_q.size() == 0);
        fif.fifo_rdata = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
      end
    end
  end

  // Line monitor: a falling tx opens a frame of exactly FRAME_CLKS cycles.
  bit         in_frame  = 1'b0;
  bit         have_prev = 1'b0;
  int         off, bit_i, exp_b, last_end;
  int         wave_err, done_err, busy_err;
  int         frames_done = 0;
  int         stray_done  = 0;
  logic [7:0] eb, dec;
  logic       exp_tx;
  logic [7:0] rx_q[$];
  int         gap_q[$];

  initial begin : line_monitor
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        in_frame  = 1'b0;
        have_prev = 1'b0;
      end else begin
        if (!in_frame && tx === 1'b0) begin
          in_frame = 1'b1;
          off      = 0;
          wave_err = 0;
          done_err = 0;
          busy_err = 0;
          dec      = 8'h00;
          if (have_prev) gap_q.push_back(cyc - last_end - 1);
          exp_b = (exp_q.size() > 0) ? int'(exp_q.pop_front()) : -1;
          eb    = exp_b[7:0];
        end
        if (in_frame) begin
          bit_i  = off / BIT_CLKS;
          exp_tx = (bit_i == 0) ? 1'b0 : (bit_i == 9) ? 1'b1 : eb[bit_i-1];
          if (tx !== exp_tx) wave_err++;
          if (tx_done !== (off == FRAME_CLKS - 1)) done_err++;
          if (tx_busy !== 1'b1) busy_err++;
          if (bit_i >= 1 && bit_i <= 8 && (off % BIT_CLKS) == BIT_CLKS / 2) dec[bit_i-1] = tx;
          if (off == FRAME_CLKS - 1) begin
            check("frame_wave", wave_err, 0);
            check("frame_done_pos", done_err, 0);
            check("frame_busy", busy_err, 0);
            check("frame_byte", {24'h0, dec}, exp_b);
            rx_q.push_back(dec);
            frames_done++;
            last_end  = cyc;
            have_prev = 1'b1;
            in_frame  = 1'b0;
          end else begin
            off++;
          end
        end else if (tx_done === 1'b1) begin
          stray_done++;
        end
      end
    end
  end

  task automatic wait_frames(input string tag, input int target, input int budget);
    int n = 0;
    while (frames_done < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, frames_done, target);
  endtask

  task automatic wait_start();
    int n = 0;
    while (tx !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  function automatic logic [31:0] rx_at(input int i);
    return (i < rx_q.size()) ? {24'h0, rx_q[i]} : 32'hDEAD;
  endfunction

  initial begin : main
    int         errs, p0, f0, k;
    logic [7:0] b;
    logic [7:0] rnd_exp[$];
    logic [7:0] s3_exp[3];

    // Reset state
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_rd", fif.fifo_rd, 0);
    check("rst_busy", tx_busy, 0);
    check("rst_done", tx_done, 0);
    reset = 1'b0;

    // Empty FIFO: line stays idle
    errs = 0;
    repeat (5000) begin
      @(negedge clk);
      if (tx !== 1'b1 || fif.fifo_rd !== 1'b0 || tx_busy !== 1'b0) errs++;
    end
    check("idle_quiet", errs, 0);

    // Single byte 0xA5
    p0 = pops; f0 = frames_done; rx_q.delete();
    fifo_q.push_back(8'hA5);
    wait_frames("a5_frames", f0 + 1, 2000);
    check("a5_pops", pops - p0, 1);
    check("a5_byte", rx_at(0), 8'hA5);
    repeat (3) @(negedge clk);
    check("a5_busy_low", tx_busy, 0);

    // Three queued bytes sent back to back
    p0 = pops; f0 = frames_done; rx_q.delete(); gap_q.delete(); have_prev = 1'b0;
    s3_exp = '{8'h00, 8'hFF, 8'h55};
    foreach (s3_exp[i]) fifo_q.push_back(s3_exp[i]);
    wait_frames("b2b_frames", f0 + 3, 6000);
    check("b2b_pops", pops - p0, 3);
    check("b2b_gap_count", gap_q.size(), 2);
    foreach (gap_q[i]) check("b2b_gap", gap_q[i], 1);
    for (int i = 0; i < 3; i++) check("b2b_byte", rx_at(i), s3_exp[i]);

    // Port changes during DATA must not reach the line
    p0 = pops; f0 = frames_done; rx_q.delete();
    fifo_q.push_back(8'hC3);
    wait_start();
    repeat (BIT_CLKS + 20) @(negedge clk);
    ovr_rdata = 8'h3C;
    ovr_empty = 1'b1;
    ovr_en    = 1'b1;
    repeat (5 * BIT_CLKS) begin
      @(negedge clk);
      ovr_empty = 1'($urandom_range(0, 1));
    end
    ovr_empty = 1'b1;
    @(negedge clk);
    ovr_en = 1'b0;
    wait_frames("hold_frames", f0 + 1, 2000);
    check("hold_pops", pops - p0, 1);
    check("hold_byte", rx_at(0), 8'hC3);

    // Reset in the middle of data bit 4 of 0x81
    p0 = pops;
    fifo_q.push_back(8'h81);
    wait_start();
    repeat (5 * BIT_CLKS + 40) @(negedge clk);
    check("mid_pre_tx", tx, 0);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_tx", tx, 1);
    check("mid_rst_busy", tx_busy, 0);
    check("mid_pops", pops - p0, 1);
    repeat (2) @(negedge clk);
    exp_q.delete();
    reset = 1'b0;
    p0 = pops; f0 = frames_done;
    errs = 0;
    repeat (2000) begin
      @(negedge clk);
      if (tx !== 1'b1) errs++;
    end
    check("post_rst_no_pop", pops - p0, 0);
    check("post_rst_no_frame", frames_done - f0, 0);
    check("post_rst_idle", errs, 0);

    // Empty low for a single clk: one pop, one frame
    p0 = pops; f0 = frames_done; rx_q.delete();
    b = 8'($urandom);
    @(negedge clk);
    ovr_rdata = b;
    ovr_empty = 1'b0;
    ovr_en    = 1'b1;
    @(negedge clk);
    ovr_empty = 1'b1;
    wait_frames("pulse_frames", f0 + 1, 2000);
    repeat (200) @(negedge clk);
    ovr_en = 1'b0;
    check("pulse_pops", pops - p0, 1);
    check("pulse_byte", rx_at(0), b);

    // Random bursts with random spacing between pushes
    for (int r = 0; r < 4; r++) begin
      k  = int'($urandom_range(1, 3));
      p0 = pops; f0 = frames_done; rx_q.delete(); rnd_exp.delete();
      for (int j = 0; j < k; j++) begin
        b = 8'($urandom);
        fifo_q.push_back(b);
        rnd_exp.push_back(b);
        repeat ($urandom_range(0, 1200)) @(negedge clk);
      end
      wait_frames("rnd_frames", f0 + k, 3000 * k);
      check("rnd_pops", pops - p0, k);
      foreach (rnd_exp[i]) check("rnd_byte", rx_at(i), rnd_exp[i]);
      repeat ($urandom_range(2, 50)) @(negedge clk);
    end

    check("no_pop_while_empty", bad_pops, 0);
    check("no_stray_done", stray_done, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
